// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA raster generator, the image-memory stage and the pins.
interface vga_timing_gen_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] rgb_in;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        video_on;
  logic        vblank;
  logic        frame_start;

  modport master (
    output pixel_x, pixel_y, vga_r, vga_g, vga_b, vga_hs, vga_vs,
           video_on, vblank, frame_start,
    input  rgb_in
  );

  modport slave (
    input  pixel_x, pixel_y, vga_r, vga_g, vga_b, vga_hs, vga_vs,
           video_on, vblank, frame_start,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock-enable pixel divider, h/v counters, and a registered
// colour/sync stage so colour and sync leave the chip pixel-aligned.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic [3:0]       r_vga_r;
  logic [3:0]       r_vga_g;
  logic [3:0]       r_vga_b;
  logic             r_vga_hs;
  logic             r_vga_vs;
  logic             r_video_on;

  logic w_pix_en;
  logic w_h_last;
  logic w_v_last;
  logic w_act;
  logic w_hs_act;
  logic w_vs_act;

  // With CLK_DIV = 1 the counter is pinned at 0, so the enable is permanently high.
  assign w_pix_en = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_h_last = (r_h_cnt == 10'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == 10'(V_TOTAL - 1));

  assign w_act    = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
  assign w_hs_act = (r_h_cnt >= 10'(H_ACTIVE + H_FP)) &&
                    (r_h_cnt <= 10'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign w_vs_act = (r_v_cnt >= 10'(V_ACTIVE + V_FP)) &&
                    (r_v_cnt <= 10'(V_ACTIVE + V_FP + V_SYNC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_pix_en) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Output stage adds exactly one pixel period of latency to colour and both syncs alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vga_r    <= '0;
      r_vga_g    <= '0;
      r_vga_b    <= '0;
      r_vga_hs   <= ~SYNC_POL;
      r_vga_vs   <= ~SYNC_POL;
      r_video_on <= 1'b0;
    end else if (w_pix_en) begin
      r_vga_r    <= w_act ? vga.rgb_in[11:8] : '0;
      r_vga_g    <= w_act ? vga.rgb_in[7:4]  : '0;
      r_vga_b    <= w_act ? vga.rgb_in[3:0]  : '0;
      r_vga_hs   <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vga_vs   <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on <= w_act;
    end
  end

  assign vga.pixel_x     = r_h_cnt;
  assign vga.pixel_y     = r_v_cnt;
  assign vga.vga_r       = r_vga_r;
  assign vga.vga_g       = r_vga_g;
  assign vga.vga_b       = r_vga_b;
  assign vga.vga_hs      = r_vga_hs;
  assign vga.vga_vs      = r_vga_vs;
  assign vga.video_on    = r_video_on;
  assign vga.vblank      = (r_v_cnt >= 10'(V_ACTIVE));
  assign vga.frame_start = !rst && w_pix_en && w_h_last && w_v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: DUT A uses default 640x480 timing at CLK_DIV=4; DUT B uses
// CLK_DIV=1 with a 15-line frame so vertical sync, wrap and mid-frame reset fit a short run.
module tb_vga_timing_gen;

  localparam int F_X   = 0;
  localparam int F_Y   = 1;
  localparam int F_R   = 2;
  localparam int F_G   = 3;
  localparam int F_B   = 4;
  localparam int F_HS  = 5;
  localparam int F_VS  = 6;
  localparam int F_VON = 7;
  localparam int F_VBL = 8;
  localparam int F_FS  = 9;

  localparam int unsigned R = 5;

  typedef struct {
    int unsigned cyc;
    int          f;
    logic [11:0] v;
    string       nm;
  } exp_t;

  logic        clk;
  logic        rst_a;
  logic        rst_b;
  int unsigned cyc;
  int unsigned n_total;
  int unsigned n_pass;
  exp_t        qa[$];
  exp_t        qb[$];

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();

  assign ifa.rgb_in = {2'b00, ifa.pixel_x};
  assign ifb.rgb_in = 12'hFFF;

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (ifa)
  );

  vga_timing_gen #(
    .CLK_DIV  (1),
    .V_ACTIVE (8),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [11:0] obs(input int d, input int f);
    case (f)
      F_X:     return (d == 0) ? 12'(ifa.pixel_x)     : 12'(ifb.pixel_x);
      F_Y:     return (d == 0) ? 12'(ifa.pixel_y)     : 12'(ifb.pixel_y);
      F_R:     return (d == 0) ? 12'(ifa.vga_r)       : 12'(ifb.vga_r);
      F_G:     return (d == 0) ? 12'(ifa.vga_g)       : 12'(ifb.vga_g);
      F_B:     return (d == 0) ? 12'(ifa.vga_b)       : 12'(ifb.vga_b);
      F_HS:    return (d == 0) ? 12'(ifa.vga_hs)      : 12'(ifb.vga_hs);
      F_VS:    return (d == 0) ? 12'(ifa.vga_vs)      : 12'(ifb.vga_vs);
      F_VON:   return (d == 0) ? 12'(ifa.video_on)    : 12'(ifb.video_on);
      F_VBL:   return (d == 0) ? 12'(ifa.vblank)      : 12'(ifb.vblank);
      default: return (d == 0) ? 12'(ifa.frame_start) : 12'(ifb.frame_start);
    endcase
  endfunction

  task automatic check(input int d, input exp_t e);
    logic [11:0] got;
    got = obs(d, e.f);
    n_total++;
    if (got === e.v) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", e.nm, cyc, got, e.v);
  endtask

  // Monitor: pops every expectation whose cycle has arrived, away from the active edge.
  initial begin
    exp_t e;
    n_total = 0;
    n_pass  = 0;
    forever begin
      @(negedge clk);
      while (qa.size() > 0 && qa[0].cyc <= cyc) begin
        e = qa.pop_front();
        check(0, e);
      end
      while (qb.size() > 0 && qb[0].cyc <= cyc) begin
        e = qb.pop_front();
        check(1, e);
      end
    end
  end

  task automatic pa(input int unsigned c, input int f, input logic [11:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.f = f; e.v = v; e.nm = nm;
    qa.push_back(e);
  endtask

  task automatic pb(input int unsigned c, input int f, input logic [11:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.f = f; e.v = v; e.nm = nm;
    qb.push_back(e);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Reset state, sampled after three reset edges.
    pa(3, F_X, 0, "A_rst_x");   pa(3, F_Y, 0, "A_rst_y");
    pa(3, F_HS, 1, "A_rst_hs"); pa(3, F_VS, 1, "A_rst_vs");
    pa(3, F_R, 0, "A_rst_r");   pa(3, F_VON, 0, "A_rst_von");
    pa(3, F_FS, 0, "A_rst_fs");
    pb(3, F_X, 0, "B_rst_x");   pb(3, F_Y, 0, "B_rst_y");
    pb(3, F_HS, 1, "B_rst_hs"); pb(3, F_VS, 1, "B_rst_vs");
    pb(3, F_G, 0, "B_rst_g");   pb(3, F_FS, 0, "B_rst_fs");

    // DUT A: k clocks after release, P = k/4 pixels counted; outputs reflect P-1.
    pa(R+3, F_X, 0, "A_x_k3");    pa(R+3, F_HS, 1, "A_hs_k3");
    pa(R+3, F_R, 0, "A_r_k3");
    pa(R+4, F_X, 1, "A_x_k4");    pa(R+4, F_HS, 1, "A_hs_k4");
    pa(R+4, F_VON, 1, "A_von_k4");
    pa(R+100, F_VBL, 0, "A_vblank");
    pa(R+1168, F_R, 12'h1, "A_r_x291"); pa(R+1168, F_G, 12'h2, "A_g_x291");
    pa(R+1168, F_B, 12'h3, "A_b_x291");
    pa(R+1171, F_R, 12'h1, "A_r_x291_hold"); pa(R+1171, F_B, 12'h3, "A_b_x291_hold");
    pa(R+1688, F_R, 12'h1, "A_r_x421"); pa(R+1688, F_G, 12'hA, "A_g_x421");
    pa(R+1688, F_B, 12'h5, "A_b_x421");
    pa(R+2560, F_R, 12'h2, "A_r_x639"); pa(R+2560, F_G, 12'h7, "A_g_x639");
    pa(R+2560, F_B, 12'hF, "A_b_x639"); pa(R+2560, F_VON, 1, "A_von_x639");
    pa(R+2564, F_R, 0, "A_r_x640");     pa(R+2564, F_G, 0, "A_g_x640");
    pa(R+2564, F_B, 0, "A_b_x640");     pa(R+2564, F_VON, 0, "A_von_x640");
    pa(R+2627, F_HS, 1, "A_hs_pre");    pa(R+2628, F_HS, 0, "A_hs_fall");
    pa(R+3011, F_HS, 0, "A_hs_last");   pa(R+3012, F_HS, 1, "A_hs_rise");
    pa(R+3199, F_X, 799, "A_x_799");    pa(R+3199, F_Y, 0, "A_y_0");
    pa(R+3199, F_FS, 0, "A_fs_linewrap");
    pa(R+3200, F_X, 0, "A_x_wrap");     pa(R+3200, F_Y, 1, "A_y_1");
    pa(R+4164, F_R, 0, "A_r_y1x240");   pa(R+4164, F_G, 12'hF, "A_g_y1x240");
    pa(R+4164, F_B, 0, "A_b_y1x240");
    pa(R+6399, F_X, 799, "A_x_799b");   pa(R+6400, F_X, 0, "A_x_wrap2");
    pa(R+6400, F_Y, 2, "A_y_2");

    // DUT B: after k clocks counts are (k%800, k/800%15); outputs reflect k-1.
    pb(R+1, F_X, 1, "B_x_k1");     pb(R+1, F_Y, 0, "B_y_k1");
    pb(R+1, F_R, 12'hF, "B_r_k1"); pb(R+1, F_VON, 1, "B_von_k1");
    pb(R+2, F_X, 2, "B_x_k2");
    pb(R+640, F_R, 12'hF, "B_r_x639"); pb(R+640, F_G, 12'hF, "B_g_x639");
    pb(R+640, F_B, 12'hF, "B_b_x639"); pb(R+640, F_VON, 1, "B_von_x639");
    pb(R+641, F_R, 0, "B_r_x640");     pb(R+641, F_G, 0, "B_g_x640");
    pb(R+641, F_B, 0, "B_b_x640");     pb(R+641, F_VON, 0, "B_von_x640");
    pb(R+656, F_HS, 1, "B_hs_pre");    pb(R+657, F_HS, 0, "B_hs_fall");
    pb(R+752, F_HS, 0, "B_hs_last");   pb(R+753, F_HS, 1, "B_hs_rise");
    pb(R+800, F_X, 0, "B_x_line");     pb(R+800, F_Y, 1, "B_y_line");
    pb(R+5601, F_R, 12'hF, "B_r_y7");  pb(R+5601, F_VON, 1, "B_von_y7");
    pb(R+6399, F_VBL, 0, "B_vbl_y7");  pb(R+6400, F_VBL, 1, "B_vbl_y8");
    pb(R+6401, F_R, 0, "B_r_y8");      pb(R+6401, F_G, 0, "B_g_y8");
    pb(R+6401, F_B, 0, "B_b_y8");      pb(R+6401, F_VON, 0, "B_von_y8");
    pb(R+8000, F_VS, 1, "B_vs_pre");   pb(R+8001, F_VS, 0, "B_vs_fall");
    pb(R+9600, F_VS, 0, "B_vs_last");  pb(R+9601, F_VS, 1, "B_vs_rise");
    pb(R+11998, F_FS, 0, "B_fs_pre");  pb(R+11999, F_FS, 1, "B_fs_pulse");
    pb(R+11999, F_X, 799, "B_x_end");  pb(R+11999, F_Y, 14, "B_y_end");
    pb(R+11999, F_VBL, 1, "B_vbl_end");
    pb(R+12000, F_FS, 0, "B_fs_post"); pb(R+12000, F_X, 0, "B_x_f0");
    pb(R+12000, F_Y, 0, "B_y_f0");     pb(R+12000, F_VBL, 0, "B_vbl_f0");
    pb(R+12001, F_R, 12'hF, "B_r_f0"); pb(R+12001, F_VON, 1, "B_von_f0");
    pb(R+21500, F_HS, 0, "B_hs_insync"); pb(R+21500, F_VS, 0, "B_vs_insync");
    pb(R+21500, F_X, 700, "B_x_700");    pb(R+21500, F_Y, 11, "B_y_11");
    pb(R+21501, F_HS, 1, "B_mrst_hs");   pb(R+21501, F_VS, 1, "B_mrst_vs");
    pb(R+21501, F_R, 0, "B_mrst_r");     pb(R+21501, F_B, 0, "B_mrst_b");
    pb(R+21501, F_X, 0, "B_mrst_x");     pb(R+21501, F_Y, 0, "B_mrst_y");
    pb(R+21501, F_VON, 0, "B_mrst_von"); pb(R+21501, F_FS, 0, "B_mrst_fs");
    pb(R+21502, F_X, 1, "B_restart_x");  pb(R+21502, F_R, 12'hF, "B_restart_r");
    pb(R+21502, F_VON, 1, "B_restart_von");
    pb(R+22301, F_X, 0, "B_restart_line_x"); pb(R+22301, F_Y, 1, "B_restart_line_y");

    while (cyc != R) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // One-clock reset on B while inside both sync pulses at (700,11).
    while (cyc != R + 21500) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;

    for (int i = 0; i < 5000 && (qa.size() + qb.size()) > 0; i++) begin
      @(negedge clk);
      #1;
    end
    while (qa.size() > 0) begin
      n_total++;
      $display("FAIL timeout_A %s got=none expected=%h", qa[0].nm, qa[0].v);
      void'(qa.pop_front());
    end
    while (qb.size() > 0) begin
      n_total++;
      $display("FAIL timeout_B %s got=none expected=%h", qb[0].nm, qb[0].v);
      void'(qb.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
